// File: rtl/halt_state_dumper.sv
// halt_state_dumper: after halt retires, streams counters, registers and post-marker memory
// as tagged valid/ready records, then a closing END record.
module halt_state_dumper #(
  parameter int          DRAIN_CYCLES = 6,
  parameter int          MEM_WORDS    = 1024,
  parameter logic [31:0] HALT_WORD    = 32'h4400_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt,
  input  logic [15:0] arith_cnt,
  input  logic [15:0] logic_cnt,
  input  logic [15:0] mem_cnt,
  input  logic [15:0] ctrl_cnt,
  input  logic [31:0] stall_wo_fwd,
  input  logic [31:0] stall_w_fwd,
  input  logic [31:0] pc,
  output logic [4:0]  reg_raddr,
  input  logic [31:0] reg_rdata,
  output logic [9:0]  mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [2:0]  dump_tag,
  output logic [9:0]  dump_index,
  output logic [31:0] dump_data,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, DRAIN, COUNT, REGS, MSCAN, MEMIT, END, DONE} state_t;
  localparam logic [2:0] TAG_COUNT = 3'd0, TAG_REG = 3'd1, TAG_MADDR = 3'd2,
                         TAG_MDATA = 3'd3, TAG_END = 3'd4;
  state_t      state, state_n;
  logic [7:0]  drain;
  logic [2:0]  cidx;
  logic [31:0] cval [8];
  logic        flag, phase, take, fire, hit, last, ld;
  logic [2:0]  ld_tag;
  logic [9:0]  ld_index;
  logic [31:0] ld_data, total;
  assign take  = !dump_valid || dump_ready;
  assign fire  = dump_valid && dump_ready;
  assign hit   = flag && mem_rdata != 32'd0;
  assign last  = mem_raddr == 10'(MEM_WORDS - 1);
  assign total = 32'(arith_cnt) + 32'(logic_cnt) + 32'(mem_cnt) + 32'(ctrl_cnt);
  assign busy  = state != IDLE && state != DONE;
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else state <= state_n;
  end
  // A new record is loaded only when the output slot is empty or being emptied.
  always_comb begin
    state_n  = state;
    ld       = 1'b0;
    ld_tag   = TAG_COUNT;
    ld_index = '0;
    ld_data  = '0;
    case (state)
      IDLE:  state_n = halt ? DRAIN : IDLE;
      DRAIN: state_n = drain <= 8'd1 ? COUNT : DRAIN;
      COUNT: begin
        ld       = take;
        ld_index = {7'd0, cidx};
        ld_data  = cval[cidx];
        state_n  = take && cidx == 3'd7 ? REGS : COUNT;
      end
      REGS: begin
        ld       = take;
        ld_tag   = TAG_REG;
        ld_index = {5'd0, reg_raddr};
        ld_data  = reg_rdata;
        state_n  = take && reg_raddr == 5'd31 ? MSCAN : REGS;
      end
      MSCAN: state_n = hit ? MEMIT : last ? END : MSCAN;
      MEMIT: begin
        ld       = take;
        ld_tag   = phase ? TAG_MDATA : TAG_MADDR;
        ld_index = mem_raddr;
        ld_data  = phase ? mem_rdata : {20'd0, mem_raddr, 2'b00};
        state_n  = take && phase ? (last ? END : MSCAN) : MEMIT;
      end
      END: begin
        ld      = take && !(dump_valid && dump_tag == TAG_END);
        ld_tag  = TAG_END;
        state_n = fire && dump_tag == TAG_END ? DONE : END;
      end
      default: state_n = state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      {dump_valid, dump_tag, dump_index, dump_data} <= '0;
      reg_raddr <= '0;
      mem_raddr <= '0;
      drain     <= '0;
      cidx      <= '0;
      flag      <= 1'b0;
      phase     <= 1'b0;
    end else begin
      if (ld) {dump_valid, dump_tag, dump_index, dump_data} <= {1'b1, ld_tag, ld_index, ld_data};
      else if (fire) {dump_valid, dump_tag, dump_index, dump_data} <= '0;
      case (state)
        IDLE: drain <= 8'(DRAIN_CYCLES);
        DRAIN: begin
          drain   <= drain - 8'd1;
          cidx    <= '0;
          cval[0] <= total;
          cval[1] <= 32'(arith_cnt);
          cval[2] <= 32'(logic_cnt);
          cval[3] <= 32'(mem_cnt);
          cval[4] <= 32'(ctrl_cnt);
          cval[5] <= pc;
          cval[6] <= total + 32'(DRAIN_CYCLES) + stall_wo_fwd;
          cval[7] <= total + 32'(DRAIN_CYCLES) + stall_w_fwd;
        end
        COUNT: if (take) begin
          cidx <= cidx + 3'd1;
          if (cidx == 3'd7) reg_raddr <= 5'd1;
        end
        REGS: if (take) reg_raddr <= reg_raddr + 5'd1;
        MSCAN: begin
          if (!flag && mem_rdata == HALT_WORD) flag <= 1'b1;
          if (!hit && !last) mem_raddr <= mem_raddr + 10'd1;
        end
        MEMIT: if (take) begin
          phase <= !phase;
          if (phase && !last) mem_raddr <= mem_raddr + 10'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_halt_state_dumper.sv
// tb_halt_state_dumper: table vectors plus randomized dumps checked against a record-list model.
module tb_halt_state_dumper;
  localparam logic [31:0] HALT_WORD = 32'h4400_0000;
  typedef struct packed {logic [2:0] tag; logic [9:0] index; logic [31:0] data;} rec_t;
  typedef struct {
    logic [15:0] a, l, m, c;
    logic [31:0] swo, sw, pcv, e_tot, e_wo, e_w;
  } vec_t;
  logic        clk = 1'b0, reset = 1'b0, halt = 1'b0, dump_ready = 1'b1;
  logic [15:0] arith_cnt, logic_cnt, mem_cnt, ctrl_cnt;
  logic [31:0] stall_wo_fwd, stall_w_fwd, pc, reg_rdata, mem_rdata, dump_data;
  logic [4:0]  reg_raddr;
  logic [9:0]  mem_raddr, dump_index;
  logic [2:0]  dump_tag;
  logic        dump_valid, busy;
  logic [31:0] regs [32];
  logic [31:0] mem [1024];
  rec_t        rx[$], ex[$];
  rec_t        held;
  bit          stalled = 1'b0;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;
  assign reg_rdata = regs[reg_raddr];
  assign mem_rdata = mem[mem_raddr];

  halt_state_dumper dut (
    .clk(clk), .reset(reset), .halt(halt),
    .arith_cnt(arith_cnt), .logic_cnt(logic_cnt), .mem_cnt(mem_cnt), .ctrl_cnt(ctrl_cnt),
    .stall_wo_fwd(stall_wo_fwd), .stall_w_fwd(stall_w_fwd), .pc(pc),
    .reg_raddr(reg_raddr), .reg_rdata(reg_rdata), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_tag(dump_tag),
    .dump_index(dump_index), .dump_data(dump_data), .busy(busy)
  );

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endfunction

  // Transfers are recorded on the falling edge ahead of the edge that completes them.
  always @(negedge clk) begin
    if (stalled) chk("hold", 64'({dump_valid, dump_tag, dump_index, dump_data}), 64'({1'b1, held}));
    held    = {dump_tag, dump_index, dump_data};
    stalled = dump_valid && !dump_ready && reset;
    if (dump_valid && dump_ready && reset) rx.push_back(held);
  end

  function automatic rec_t mk(input int t, input int i, input logic [31:0] d);
    return {3'(t), 10'(i), d};
  endfunction

  function automatic void build_exp();
    logic [31:0] tot;
    bit seen = 1'b0;
    tot = 32'(arith_cnt) + 32'(logic_cnt) + 32'(mem_cnt) + 32'(ctrl_cnt);
    ex.delete();
    ex.push_back(mk(0, 0, tot));
    ex.push_back(mk(0, 1, 32'(arith_cnt)));
    ex.push_back(mk(0, 2, 32'(logic_cnt)));
    ex.push_back(mk(0, 3, 32'(mem_cnt)));
    ex.push_back(mk(0, 4, 32'(ctrl_cnt)));
    ex.push_back(mk(0, 5, pc));
    ex.push_back(mk(0, 6, tot + 32'd6 + stall_wo_fwd));
    ex.push_back(mk(0, 7, tot + 32'd6 + stall_w_fwd));
    for (int i = 1; i < 32; i++) ex.push_back(mk(1, i, regs[i]));
    for (int i = 0; i < 1024; i++) begin
      if (!seen) seen = mem[i] == HALT_WORD;
      else if (mem[i] != 32'd0) begin
        ex.push_back(mk(2, i, 32'(i) * 32'd4));
        ex.push_back(mk(3, i, mem[i]));
      end
    end
    ex.push_back(mk(4, 0, 32'd0));
  endfunction

  task automatic apply_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    dump_ready = 1'b1;
  endtask

  task automatic set_spec_state();
    for (int i = 0; i < 32; i++) regs[i] = -32'(i);
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[10] = HALT_WORD;
    mem[12] = 32'd99;
    mem[3]  = 32'd7;
  endtask

  task automatic run_dump(input bit rnd, input string nm);
    int lat;
    bit done;
    lat  = 0;
    done = 1'b0;
    rx.delete();
    dump_ready = 1'b1;
    @(posedge clk);
    #1 halt = 1'b1;
    @(posedge clk);
    #1 halt = 1'b0;
    @(negedge clk);
    chk({nm, " busy rise"}, 64'(busy), 64'd1);
    while (!dump_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " first latency"}, 64'(lat), 64'd7);
    for (int c = 0; c < 6000 && !done; c++) begin
      @(posedge clk);
      #1 dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      done = rx.size() > 0 && rx[$].tag == 3'd4;
    end
    chk({nm, " END within budget"}, 64'(done), 64'd1);
    @(negedge clk);
    chk({nm, " busy after END"}, 64'({busy, dump_valid}), 64'd0);
    @(posedge clk);
    #1 halt = 1'b1;
    @(posedge clk);
    #1 halt = 1'b0;
    repeat (10) @(negedge clk);
    chk({nm, " halt ignored in DONE"}, 64'({busy, dump_valid}), 64'd0);
    chk({nm, " record count"}, 64'(rx.size()), 64'(ex.size()));
    for (int i = 0; i < ex.size() && i < rx.size(); i++)
      chk($sformatf("%s rec %0d", nm, i), 64'(rx[i]), 64'(ex[i]));
  endtask

  initial begin
    vec_t        tbl [3];
    logic [31:0] ce [8];
    bit          has_end;
    tbl[0] = '{16'd5, 16'd3, 16'd2, 16'd1, 32'd7, 32'd2, 32'h40, 32'd11, 32'd24, 32'd19};
    tbl[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFF_FFF0, 32'd0, 32'h1000,
               32'h0003_FFFC, 32'h0003_FFF2, 32'h0004_0002};
    tbl[2] = '{16'd0, 16'd0, 16'd0, 16'd0, 32'd0, 32'd0, 32'hDEAD_BEEF, 32'd0, 32'd6, 32'd6};
    set_spec_state();
    {arith_cnt, logic_cnt, mem_cnt, ctrl_cnt} = '0;
    {stall_wo_fwd, stall_w_fwd, pc} = '0;
    reset = 1'b0;
    halt  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("reset valid/busy", 64'({dump_valid, busy}), 64'd0);
    end
    chk("reset outputs", 64'({dump_tag, dump_index, dump_data, reg_raddr, mem_raddr}), 64'd0);
    chk("reset no records", 64'(rx.size()), 64'd0);
    @(posedge clk);
    #1 halt = 1'b0;
    reset = 1'b1;
    for (int v = 0; v < 3; v++) begin
      {arith_cnt, logic_cnt, mem_cnt, ctrl_cnt} = {tbl[v].a, tbl[v].l, tbl[v].m, tbl[v].c};
      {stall_wo_fwd, stall_w_fwd, pc} = {tbl[v].swo, tbl[v].sw, tbl[v].pcv};
      build_exp();
      run_dump(1'b0, $sformatf("tbl%0d", v));
      ce = '{tbl[v].e_tot, 32'(tbl[v].a), 32'(tbl[v].l), 32'(tbl[v].m), 32'(tbl[v].c),
             tbl[v].pcv, tbl[v].e_wo, tbl[v].e_w};
      for (int k = 0; k < 8; k++)
        chk($sformatf("tbl%0d count %0d", v, k), 64'(rx.size() > k ? rx[k].data : 32'hxxxx_xxxx), 64'(ce[k]));
      chk($sformatf("tbl%0d R5", v), 64'(rx.size() > 12 ? rx[12].data : 32'hxxxx_xxxx), 64'hFFFF_FFFB);
      chk($sformatf("tbl%0d mem addr", v), 64'(rx.size() > 39 ? rx[39] : '0), 64'({3'd2, 10'd12, 32'd48}));
      apply_reset();
    end
    {arith_cnt, logic_cnt, mem_cnt, ctrl_cnt} = {tbl[0].a, tbl[0].l, tbl[0].m, tbl[0].c};
    {stall_wo_fwd, stall_w_fwd, pc} = {tbl[0].swo, tbl[0].sw, tbl[0].pcv};
    build_exp();
    run_dump(1'b1, "rnd_ready");
    apply_reset();
    rx.delete();
    @(posedge clk);
    #1 halt = 1'b1;
    @(posedge clk);
    #1 halt = 1'b0;
    for (int c = 0; c < 300 && rx.size() < 20; c++) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort valid/busy", 64'({dump_valid, busy}), 64'd0);
    chk("abort during REGS", 64'(rx.size() >= 8 && rx.size() < 39), 64'd1);
    has_end = 1'b0;
    foreach (rx[i]) if (rx[i].tag == 3'd4) has_end = 1'b1;
    chk("abort no END", 64'(has_end), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    run_dump(1'b0, "rerun");
    apply_reset();
    for (int r = 0; r < 4; r++) begin
      int mk_at;
      {arith_cnt, logic_cnt, mem_cnt, ctrl_cnt} = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      {stall_wo_fwd, stall_w_fwd, pc} = {$urandom, $urandom, $urandom};
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
      for (int k = 0; k < 40; k++) mem[$urandom_range(0, 1023)] = $urandom | 32'd1;
      mk_at = r == 0 ? -1 : r == 1 ? 1023 : r == 3 ? 0 : int'($urandom_range(1, 900));
      if (mk_at >= 0) mem[mk_at] = HALT_WORD;
      if (r == 2) begin
        mem[950]  = HALT_WORD;
        mem[1023] = 32'hCAFE_0001;
      end
      build_exp();
      run_dump(r[0], $sformatf("rand%0d", r));
      apply_reset();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
